// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds the response-owner encoding and the word/strobe widths.
package mem_arb_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D_LD = 2'd2,
    OWN_D_ST = 2'd3
  } resp_own_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Fetch starvation counter: counts consecutive cycles fetch loses.
// Ports: clk, rst_n, i_req, i_win in; force_i out (fetch must win now).
module mem_arb_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_win,
  output logic force_i
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign force_i = i_req && (cnt_q == LIMIT);

  // A forced win counts as a grant, so the counter clears on it.
  always_comb begin
    cnt_d = 8'd0;
    if (i_req && !i_win) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch (I) and LSU (D).
// Ports: i_* fetch side, d_* data side, mem_* RAM side; clk, rst_n.
// Optional: MEM_ARB_STARVE_GUARD_EN adds the fetch starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [WORD_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [STRB_W-1:0] d_wstrb,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [WORD_W-1:0] d_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  logic      force_i;
  logic      i_win;
  logic      d_win;
  resp_own_e own_q;
  resp_own_e own_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (i_req),
    .i_win  (i_win),
    .force_i(force_i)
  );
`else
  // No guard: the limit is meaningless and D always beats I.
  assign force_i = (STARVE_LIMIT < 0);
`endif

  assign i_win = i_req && (!d_req || force_i);
  assign d_win = d_req && !i_win;

  // Grants and the port request are masked while reset is held.
  assign i_gnt   = rst_n && i_win;
  assign d_gnt   = rst_n && d_win;
  assign mem_req = rst_n && (i_req || d_req);

  always_comb begin
    mem_addr  = i_addr;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_wdata = '0;
    own_d     = OWN_NONE;
    unique case (1'b1)
      i_win: begin
        own_d = OWN_I;
      end
      d_win: begin
        mem_addr  = d_addr;
        mem_we    = d_we;
        mem_wstrb = d_we ? d_wstrb : '0;
        mem_wdata = d_wdata;
        own_d     = d_we ? OWN_D_ST : OWN_D_LD;
      end
      default: begin
        own_d = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q <= OWN_NONE;
    end else begin
      own_q <= own_d;
    end
  end

  assign i_rvalid = (own_q == OWN_I);
  assign d_rvalid = (own_q == OWN_D_LD) || (own_q == OWN_D_ST);
  assign i_rdata  = (own_q == OWN_I) ? mem_rdata : '0;
  assign d_rdata  = (own_q == OWN_D_LD) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural RAM.
// Directed test-plan cases followed by randomized traffic.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int LIM = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_we = 1'b0;
  logic [3:0]    d_wstrb = '0;
  logic [31:0]   d_wdata = '0;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wstrb  (d_wstrb),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h0000_0513;
    if (i == 64) return 32'h1122_3344;
    return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Device model of the RAM, driven only by the DUT's port.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else if (mem_req) begin
      if (mem_we) begin
        for (int k = 0; k < 4; k++)
          if (mem_wstrb[k])
            ram[mem_addr[9:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
      end
      mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  // Reference state: a word-array image and a lost-cycle count.
  logic [31:0] refm [256];
  logic [65:0] sb[$];
  int lost = 0;
  int total = 0;
  int bad = 0;

  always @(negedge clk) begin
    logic [65:0] e;
    logic [65:0] a;
    a = {i_rvalid, i_rdata, d_rvalid, d_rdata};
    e = (sb.size() == 0) ? 66'd0 : sb.pop_front();
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL resp t=%0t got iv=%0b id=%h dv=%0b dd=%h want iv=%0b id=%h dv=%0b dd=%h",
               $time, a[65], a[64:33], a[32], a[31:0],
               e[65], e[64:33], e[32], e[31:0]);
    end
  end

  // One arbitration cycle; called just after a rising edge.
  task automatic cyc(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic [31:0] da,
                     input logic dw, input logic [3:0] ds,
                     input logic [31:0] dd,
                     output logic ig, output logic dg);
    logic        iw;
    logic        dwn;
    logic [2:0]  eg;
    logic [68:0] em;
    logic [68:0] am;
    logic [65:0] resp;
    logic [7:0]  ix;
    i_req = ir; i_addr = ia;
    d_req = dr; d_addr = da; d_we = dw; d_wstrb = ds; d_wdata = dd;
    iw  = ir && (!dr || (GUARD && lost == LIM));
    dwn = dr && !iw;
    ig = iw; dg = dwn;
    eg = {iw, dwn, ir || dr};
    em = dwn ? {da, dw, dw ? ds : 4'd0, dd} : {ia, 1'b0, 4'd0, 32'd0};
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, mem_req} !== eg) begin
      bad++;
      $display("FAIL gnt t=%0t got ig/dg/rq=%b want %b",
               $time, {i_gnt, d_gnt, mem_req}, eg);
    end
    if (ir || dr) begin
      am = {mem_addr, mem_we, mem_wstrb, mem_wdata};
      total++;
      if (am !== em) begin
        bad++;
        $display("FAIL port t=%0t got a=%h we=%b s=%b w=%h want a=%h we=%b s=%b w=%h",
                 $time, am[68:37], am[36], am[35:32], am[31:0],
                 em[68:37], em[36], em[35:32], em[31:0]);
      end
    end
    @(posedge clk);
    resp = '0;
    if (iw) begin
      ix = ia[9:2];
      resp = {1'b1, refm[ix], 1'b0, 32'd0};
    end else if (dwn) begin
      ix = da[9:2];
      if (dw) begin
        for (int k = 0; k < 4; k++)
          if (ds[k]) refm[ix][8*k +: 8] = dd[8*k +: 8];
        resp = {1'b0, 32'd0, 1'b1, 32'd0};
      end else begin
        resp = {1'b0, 32'd0, 1'b1, refm[ix]};
      end
    end
    sb.push_back(resp);
    lost = (ir && !iw) ? lost + 1 : 0;
    #1;
  endtask

  // Reset with both requests raised to show everything is masked.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    sb.delete();
    sb.push_back('0);
    lost = 0;
    for (int i = 0; i < 256; i++) refm[i] = init_word(i);
    repeat (n) begin
      @(negedge clk);
      total++;
      if ({i_gnt, d_gnt, mem_req} !== 3'b000) begin
        bad++;
        $display("FAIL rst_out got ig/dg/rq=%b want 000",
                 {i_gnt, d_gnt, mem_req});
      end
      @(posedge clk);
      sb.push_back('0);
    end
    #1;
    rst_n = 1'b1;
    i_req = 1'b0; d_req = 1'b0;
  endtask

  logic        ig;
  logic        dg;
  logic        ip;
  logic        dp;
  logic [31:0] ra;
  logic [31:0] rd;
  logic        rw;
  logic [3:0]  rs;
  logic [31:0] rv;

  initial begin
    do_reset(3);
    // I-only fetch of 0x10.
    cyc(1, 32'h10, 0, 0, 0, 0, 0, ig, dg);
    cyc(0, 0, 0, 0, 0, 0, 0, ig, dg);
    // Partial store then load of 0x100.
    cyc(0, 0, 1, 32'h100, 1, 4'b0011, 32'hDEADBEEF, ig, dg);
    cyc(0, 0, 1, 32'h100, 0, 4'b0000, 32'h0, ig, dg);
    cyc(0, 0, 0, 0, 0, 0, 0, ig, dg);
    // Both requesting for three cycles; I waits, then wins.
    cyc(1, 32'h20, 1, 32'h40, 0, 0, 0, ig, dg);
    cyc(1, 32'h20, 1, 32'h44, 0, 0, 0, ig, dg);
    cyc(1, 32'h20, 1, 32'h48, 0, 0, 0, ig, dg);
    cyc(1, 32'h20, 0, 0, 0, 0, 0, ig, dg);
    cyc(0, 0, 0, 0, 0, 0, 0, ig, dg);
    // Both held for a long run: starvation pattern when guarded.
    for (int c = 0; c < 12; c++)
      cyc(1, 32'h30, 1, 32'h80 + 32'(4 * c), 0, 0, 0, ig, dg);
    cyc(0, 0, 0, 0, 0, 0, 0, ig, dg);
    // Reset one cycle after a load grant drops its response.
    cyc(0, 0, 1, 32'h100, 0, 0, 0, ig, dg);
    do_reset(2);
    cyc(0, 0, 0, 0, 0, 0, 0, ig, dg);
    cyc(1, 32'h0, 0, 0, 0, 0, 0, ig, dg);
    cyc(1, 32'h4, 0, 0, 0, 0, 0, ig, dg);
    cyc(1, 32'h8, 0, 0, 0, 0, 0, ig, dg);
    cyc(0, 0, 0, 0, 0, 0, 0, ig, dg);
    // Misaligned addresses pass straight through.
    cyc(1, 32'h13, 0, 0, 0, 0, 0, ig, dg);
    cyc(0, 0, 1, 32'h101, 0, 0, 0, ig, dg);
    // Random traffic with hold-until-grant requesters.
    ip = 0; dp = 0; ra = 0; rd = 0; rw = 0; rs = 0; rv = 0;
    for (int c = 0; c < 600; c++) begin
      if (!ip && ($urandom % 3 != 0)) begin
        ra = 32'($urandom % 1024);
        if ($urandom % 8 != 0) ra[1:0] = 2'b00;
        ip = 1;
      end
      if (!dp && ($urandom % 3 == 0)) begin
        rd = 32'($urandom % 1024);
        if ($urandom % 8 != 0) rd[1:0] = 2'b00;
        rw = 1'($urandom % 2);
        rs = 4'($urandom);
        rv = $urandom;
        dp = 1;
      end
      cyc(ip, ra, dp, rd, rw, rs, rv, ig, dg);
      if (ig) ip = 0;
      if (dg) dp = 0;
      if (c == 300) do_reset(2);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, ig, dg);
    cyc(0, 0, 0, 0, 0, 0, 0, ig, dg);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
